// File: rtl/branch_predict_gshare.sv
// Gshare conditional-branch predictor: PC^GHR indexes a 2-bit counter PHT, trained in M, GHR repaired on mispredict.
// Optional macro BP_STATS_EN adds branch and mispredict event counters.
module branch_predict_gshare #(
  parameter int unsigned PHT_DEPTH = 10,
  parameter int unsigned GHR_LEN   = 10,
  parameter int unsigned PC_LSB    = 2,
  parameter logic [1:0]  INIT_CTR  = 2'b10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallD,
  input  logic               flushD,
  input  logic [31:0]        pcF,
  input  logic [31:0]        instrF,
  output logic               pred_takeD,
  output logic [GHR_LEN-1:0] ghrD,
  input  logic               branchM,
  input  logic               actual_takeM,
  input  logic               pred_takeM,
  input  logic [31:0]        pcM,
  input  logic [GHR_LEN-1:0] ghrM,
`ifdef BP_STATS_EN
  output logic [31:0]        stat_branches,
  output logic [31:0]        stat_mispredicts,
`endif
  output logic               ready
);

  localparam int unsigned PHT_SIZE = 1 << PHT_DEPTH;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e               state_q, state_d;
  logic [PHT_DEPTH-1:0] cnt_q, cnt_d;
  logic [GHR_LEN-1:0]   ghr_q, ghr_d;
  logic                 pred_takeD_q;
  logic [GHR_LEN-1:0]   ghrD_q;
  logic [1:0]           pht_q [PHT_SIZE];

  logic                 run;
  logic                 branchF;
  logic                 pred_takeF;
  logic                 mispredictM;
  logic [PHT_DEPTH-1:0] idxF, idxM;
  logic [1:0]           ctrF, ctrM, ctrM_upd;
  logic                 pht_we;
  logic [PHT_DEPTH-1:0] pht_waddr;
  logic [1:0]           pht_wdata;
  logic [GHR_LEN:0]     ghr_rep, ghr_shf;
  logic                 unused_bits;

  assign run     = (state_q == S_RUN);
  assign branchF = instrF[31:26] inside {6'b000100, 6'b000101, 6'b000001, 6'b000111, 6'b000110};

  assign idxF = pcF[PC_LSB +: PHT_DEPTH] ^ PHT_DEPTH'(ghr_q);
  assign idxM = pcM[PC_LSB +: PHT_DEPTH] ^ PHT_DEPTH'(ghrM);
  assign ctrF = pht_q[idxF];
  assign ctrM = pht_q[idxM];

  assign pred_takeF  = run & branchF & ctrF[1];
  assign mispredictM = branchM & (actual_takeM != pred_takeM);

  assign ctrM_upd = actual_takeM ? ((ctrM == 2'b11) ? 2'b11 : ctrM + 2'd1)
                                 : ((ctrM == 2'b00) ? 2'b00 : ctrM - 2'd1);

  // One bit wider so the shift also works when GHR_LEN is 1.
  assign ghr_rep = {ghrM, actual_takeM};
  assign ghr_shf = {ghr_q, pred_takeF};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ghr_d     = ghr_q;
    pht_we    = 1'b0;
    pht_waddr = cnt_q;
    pht_wdata = INIT_CTR;
    if (state_q == S_INIT) begin
      pht_we = 1'b1;
      cnt_d  = cnt_q + PHT_DEPTH'(1);
      if (cnt_q == '1) begin
        state_d = S_RUN;
      end
    end else begin
      if (branchM) begin
        pht_we    = 1'b1;
        pht_waddr = idxM;
        pht_wdata = ctrM_upd;
      end
      // Repair from the checkpoint wins over a speculative shift in the same cycle.
      if (mispredictM) begin
        ghr_d = ghr_rep[GHR_LEN-1:0];
      end else if (branchF && !stallD && !flushD) begin
        ghr_d = ghr_shf[GHR_LEN-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      ghr_q        <= '0;
      pred_takeD_q <= 1'b0;
      ghrD_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ghr_q   <= ghr_d;
      if (flushD) begin
        pred_takeD_q <= 1'b0;
        ghrD_q       <= '0;
      end else if (!stallD) begin
        pred_takeD_q <= pred_takeF;
        ghrD_q       <= ghr_q;
      end
    end
  end

  // No reset on the table itself: the INIT sweep fills it.
  always_ff @(posedge clk) begin
    if (pht_we && !rst) begin
      pht_q[pht_waddr] <= pht_wdata;
    end
  end

  assign pred_takeD = pred_takeD_q;
  assign ghrD       = ghrD_q;
  assign ready      = run;

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_mispredicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (run && branchM) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredictM) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

  assign unused_bits = ^{pcF, pcM, instrF[25:0]};

endmodule
